// File: rtl/ula_pkg.sv
// ula_pkg: opcodes and datapath width shared by the ULA files.
// Contents: OP_* selector codes, ULA_W data width.
package ula_pkg;

  localparam int ULA_W = 8;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;

endpackage

// File: rtl/ula_ripple_adder8.sv
// ula_ripple_adder8: 8-bit ripple-carry adder from full-adder cells.
// Ports: a, b (8b), cin -> sum (8b), cout.
module ula_ripple_adder8
  import ula_pkg::*;
(
  input  logic [ULA_W-1:0] a,
  input  logic [ULA_W-1:0] b,
  input  logic             cin,
  output logic [ULA_W-1:0] sum,
  output logic             cout
);

  logic [ULA_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < ULA_W; i++) begin : g_fa
    logic p;
    assign p        = a[i] ^ b[i];
    assign sum[i]   = p ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (p & c[i]);
  end

  assign cout = c[ULA_W];

endmodule

// File: rtl/ula_8bits.sv
// ula_8bits: 8-bit registered ALU (AND/OR/NOT/NAND/ADD/SUB), 1-cycle latency.
// Ports: clk, rst (sync, active-high), A, B, carry_in, seletor (3b)
//   -> resultado (8b), carry_out; with ULA_FLAGS_EN also zero, overflow.
module ula_8bits
  import ula_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [ULA_W-1:0] A,
  input  logic [ULA_W-1:0] B,
  input  logic             carry_in,
  input  logic [2:0]       seletor,
`ifdef ULA_FLAGS_EN
  output logic             zero,
  output logic             overflow,
`endif
  output logic [ULA_W-1:0] resultado,
  output logic             carry_out
);

  logic             is_sub;
  logic [ULA_W-1:0] add_b;
  logic             add_cin;
  logic [ULA_W-1:0] add_sum;
  logic             add_cout;
  logic [ULA_W-1:0] res_d;
  logic             co_d;
  logic             ov_d;

  // SUB reuses the adder: A + ~B + ~borrow_in, borrow_out = ~cout.
  assign is_sub  = (seletor == OP_SUB);
  assign add_b   = is_sub ? ~B : B;
  assign add_cin = is_sub ? ~carry_in : carry_in;

  ula_ripple_adder8 u_adder (
    .a    (A),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    res_d = '0;
    co_d  = 1'b0;
    ov_d  = 1'b0;
    unique case (1'b1)
      (seletor == OP_AND):  res_d = A & B;
      (seletor == OP_OR):   res_d = A | B;
      (seletor == OP_NOT):  res_d = ~A;
      (seletor == OP_NAND): res_d = ~(A & B);
      (seletor == OP_ADD): begin
        res_d = add_sum;
        co_d  = add_cout;
        ov_d  = (A[ULA_W-1] == B[ULA_W-1]) &&
                (add_sum[ULA_W-1] != A[ULA_W-1]);
      end
      (seletor == OP_SUB): begin
        res_d = add_sum;
        co_d  = ~add_cout;
        ov_d  = (A[ULA_W-1] != B[ULA_W-1]) &&
                (add_sum[ULA_W-1] != A[ULA_W-1]);
      end
      default: begin
        res_d = '0;
        co_d  = 1'b0;
        ov_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resultado <= '0;
      carry_out <= 1'b0;
    end else begin
      resultado <= res_d;
      carry_out <= co_d;
    end
  end

`ifdef ULA_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      zero     <= (res_d == '0);
      overflow <= ov_d;
    end
  end
`else
  logic unused_ov;
  assign unused_ov = ov_d;
`endif

endmodule

// File: tb/tb_ula_8bits.sv
// tb_ula_8bits: directed self-checking bench for ula_8bits.
// Drives inputs #1 after posedge, checks #1 after the capturing edge.
module tb_ula_8bits;
  import ula_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic       carry_in;
  logic [2:0] seletor;
  logic [7:0] resultado;
  logic       carry_out;
`ifdef ULA_FLAGS_EN
  logic       zero;
  logic       overflow;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ula_8bits dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .carry_in  (carry_in),
    .seletor   (seletor),
`ifdef ULA_FLAGS_EN
    .zero      (zero),
    .overflow  (overflow),
`endif
    .resultado (resultado),
    .carry_out (carry_out)
  );

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag,
                      input logic [7:0] a,
                      input logic [7:0] b,
                      input logic       cin,
                      input logic [2:0] sel,
                      input logic [7:0] exp_r,
                      input logic       exp_c);
    A        = a;
    B        = b;
    carry_in = cin;
    seletor  = sel;
    tick();
    check({tag, ".res"}, resultado, exp_r);
    check({tag, ".co"}, {7'd0, carry_out}, {7'd0, exp_c});
  endtask

  initial begin
    rst      = 1'b1;
    A        = 8'hFF;
    B        = 8'hFF;
    carry_in = 1'b0;
    seletor  = OP_ADD;
    tick();
    tick();
    check("rst.res", resultado, 8'h00);
    check("rst.co", {7'd0, carry_out}, 8'h00);
`ifdef ULA_FLAGS_EN
    check("rst.z", {7'd0, zero}, 8'h00);
    check("rst.ov", {7'd0, overflow}, 8'h00);
`endif
    rst = 1'b0;
    step("first", 8'hFF, 8'hFF, 1'b0, OP_ADD, 8'hFE, 1'b1);

    step("and",  8'hCC, 8'hAA, 1'b0, OP_AND,  8'h88, 1'b0);
    step("or",   8'hCC, 8'hAA, 1'b1, OP_OR,   8'hEE, 1'b0);
    step("not",  8'hF0, 8'hAA, 1'b0, OP_NOT,  8'h0F, 1'b0);
    step("nand", 8'hAA, 8'h55, 1'b1, OP_NAND, 8'hFF, 1'b0);

    step("add0", 8'h0F, 8'h01, 1'b0, OP_ADD, 8'h10, 1'b0);
    step("add1", 8'h0F, 8'h01, 1'b1, OP_ADD, 8'h11, 1'b0);
    step("addw", 8'hFF, 8'h01, 1'b0, OP_ADD, 8'h00, 1'b1);

    step("sub0", 8'h80, 8'h01, 1'b0, OP_SUB, 8'h7F, 1'b0);
    step("sub1", 8'h80, 8'h01, 1'b1, OP_SUB, 8'h7E, 1'b0);
    step("subw", 8'h00, 8'h01, 1'b0, OP_SUB, 8'hFF, 1'b1);
    step("subq", 8'h05, 8'h04, 1'b1, OP_SUB, 8'h00, 1'b0);

    step("r111", 8'hFF, 8'hFF, 1'b1, 3'b111, 8'h00, 1'b0);
    step("r110", 8'h12, 8'h34, 1'b1, 3'b110, 8'h00, 1'b0);

    step("b2b.and", 8'h3C, 8'h0F, 1'b0, OP_AND, 8'h0C, 1'b0);
    step("b2b.add", 8'h3C, 8'h0F, 1'b0, OP_ADD, 8'h4B, 1'b0);
    step("b2b.sub", 8'h3C, 8'h0F, 1'b0, OP_SUB, 8'h2D, 1'b0);
    step("b2b.add2", 8'hF0, 8'h20, 1'b1, OP_ADD, 8'h11, 1'b1);

    // Reset lands on the edge that would capture this ADD.
    rst = 1'b1;
    step("rst.mid", 8'hF0, 8'h20, 1'b1, OP_ADD, 8'h00, 1'b0);
    rst = 1'b0;
    step("rst.rec", 8'hF0, 8'h20, 1'b1, OP_ADD, 8'h11, 1'b1);

`ifdef ULA_FLAGS_EN
    step("ovf", 8'h7F, 8'h01, 1'b0, OP_ADD, 8'h80, 1'b0);
    check("ovf.ov", {7'd0, overflow}, 8'h01);
    check("ovf.z", {7'd0, zero}, 8'h00);
    step("zsub", 8'h05, 8'h05, 1'b0, OP_SUB, 8'h00, 1'b0);
    check("zsub.z", {7'd0, zero}, 8'h01);
    check("zsub.ov", {7'd0, overflow}, 8'h00);
    step("sovf", 8'h80, 8'h01, 1'b0, OP_SUB, 8'h7F, 1'b0);
    check("sovf.ov", {7'd0, overflow}, 8'h01);
    step("lz", 8'hF0, 8'h0F, 1'b0, OP_AND, 8'h00, 1'b0);
    check("lz.z", {7'd0, zero}, 8'h01);
    check("lz.ov", {7'd0, overflow}, 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
